// File: rtl/alu_seq_if.sv
// Handshake/result bundle between the control unit (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_c;
    logic             flag_v;
    logic             flag_z;
    logic             flag_n;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, result_hi, flag_c, flag_v, flag_z, flag_n
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, result_hi, flag_c, flag_v, flag_z, flag_n
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with C/V/Z/N flag register, carry-chained ADC/SBB and a
// WIDTH-cycle shift-add multiplier behind a valid/ready input handshake.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave alu
);
    localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBB = 3'd3,
                           OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_MUL = 3'd7;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   ma_q, mb_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, step_term;
    logic               out_valid_q;
    logic [WIDTH-1:0]   res_q, res_hi_q;
    logic               c_q, v_q, z_q, n_q;

    logic [WIDTH-1:0]   y;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c, alu_v;
    logic               accept;

    assign alu.in_ready  = rst_n & (state_q == S_IDLE);
    assign accept        = alu.in_valid & alu.in_ready;
    assign alu.out_valid = out_valid_q;
    assign alu.result    = res_q;
    assign alu.result_hi = res_hi_q;
    assign alu.flag_c    = c_q;
    assign alu.flag_v    = v_q;
    assign alu.flag_z    = z_q;
    assign alu.flag_n    = n_q;

    // c_q is already the previous op's carry, so back-to-back ADC/SBB chain without a stall.
    always_comb begin
        y   = alu.b;
        cin = 1'b0;
        case (alu.op)
            OP_ADC:  cin = c_q;
            OP_SUB:  begin y = ~alu.b; cin = 1'b1; end
            OP_SBB:  begin y = ~alu.b; cin = c_q;  end
            default: ;
        endcase
        sum   = {1'b0, alu.a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (~alu.a[WIDTH-1] & ~y[WIDTH-1] &  sum[WIDTH-1]) |
                ( alu.a[WIDTH-1] &  y[WIDTH-1] & ~sum[WIDTH-1]);
        case (alu.op)
            OP_AND:  begin alu_r = alu.a & alu.b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_OR:   begin alu_r = alu.a | alu.b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_XOR:  begin alu_r = alu.a ^ alu.b; alu_c = 1'b0; alu_v = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        step_term = ma_q[cnt_q] ? ({{WIDTH{1'b0}}, mb_q} << cnt_q) : '0;
        acc_d     = acc_q + step_term;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_hi_q    <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (alu.op == OP_MUL) begin
                            ma_q    <= alu.a;
                            mb_q    <= alu.b;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_MUL;
                        end else begin
                            res_q       <= alu_r;
                            res_hi_q    <= '0;
                            c_q         <= alu_c;
                            v_q         <= alu_v;
                            z_q         <= (alu_r == '0);
                            n_q         <= alu_r[WIDTH-1];
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        res_q       <= acc_d[WIDTH-1:0];
                        res_hi_q    <= acc_d[2*WIDTH-1:WIDTH];
                        c_q         <= |acc_d[2*WIDTH-1:WIDTH];
                        v_q         <= |acc_d[2*WIDTH-1:WIDTH];
                        z_q         <= (acc_d == '0);
                        n_q         <= acc_d[WIDTH-1];
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16 with directed vectors.
module tb_alu_seq;
    localparam logic [2:0] ADD = 3'd0, ADC = 3'd1, SUB = 3'd2, SBB = 3'd3,
                           AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, MUL = 3'd7;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  f;   // {c,v,z,n}
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cmp = 0;
    int   err = 0;
    exp_t q8[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  if8();
    alu_seq_if #(.WIDTH(16)) if16();
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .alu(if8.slave));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .alu(if16.slave));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitors: pop and compare on every out_valid pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && if8.out_valid === 1'b1) begin
            if (q8.size() == 0) begin
                cmp++; err++;
                $display("FAIL w8_unexpected_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8_result",    {24'd0, if8.result},    {16'd0, e.lo});
                check("w8_result_hi", {24'd0, if8.result_hi}, {16'd0, e.hi});
                check("w8_flags_cvzn", {28'd0, if8.flag_c, if8.flag_v, if8.flag_z, if8.flag_n}, {28'd0, e.f});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && if16.out_valid === 1'b1) begin
            if (q16.size() == 0) begin
                cmp++; err++;
                $display("FAIL w16_unexpected_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check("w16_result",    {16'd0, if16.result},    {16'd0, e.lo});
                check("w16_result_hi", {16'd0, if16.result_hi}, {16'd0, e.hi});
                check("w16_flags_cvzn", {28'd0, if16.flag_c, if16.flag_v, if16.flag_z, if16.flag_n}, {28'd0, e.f});
            end
        end
    end

    function automatic logic rdy(input int w);
        return (w == 8) ? if8.in_ready : if16.in_ready;
    endfunction

    function automatic logic ovld(input int w);
        return (w == 8) ? if8.out_valid : if16.out_valid;
    endfunction

    task automatic drive(input int w, input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (w == 8) begin
            if8.in_valid = v; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
        end else begin
            if16.in_valid = v; if16.op = op; if16.a = a; if16.b = b;
        end
    endtask

    // Returns 1ns after the accepting edge with in_valid dropped.
    task automatic send(input int w, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] lo, input logic [15:0] hi, input logic [3:0] f, input bit push);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        drive(w, 1'b1, op, a, b);
        while (!rdy(w) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            cmp++; err++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        e.lo = lo; e.hi = hi; e.f = f;
        if (push) begin
            if (w == 8) q8.push_back(e);
            else        q16.push_back(e);
        end
        @(posedge clk);
        #1 drive(w, 1'b0, ADD, 16'd0, 16'd0);
    endtask

    task automatic mul_lat(input int w, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] lo, input logic [15:0] hi, input logic [3:0] f);
        int k;
        int low;
        k = 0; low = 0;
        send(w, MUL, a, b, lo, hi, f, 1'b1);
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (!rdy(w)) low++;
            if (ovld(w)) break;
        end
        check($sformatf("w%0d_mul_latency", w), k, w + 1);
        check($sformatf("w%0d_mul_ready_low", w), low, w);
    endtask

    task automatic arith_suite(input int w);
        logic [15:0] ones, maxp, minn;
        ones = (w == 8) ? 16'h00FF : 16'hFFFF;
        maxp = (w == 8) ? 16'h007F : 16'h7FFF;
        minn = (w == 8) ? 16'h0080 : 16'h8000;
        send(w, ADD, ones, 16'd1, 16'd0, 16'd0, 4'b1010, 1'b1);
        @(negedge clk);
        check($sformatf("w%0d_add_latency_1", w), {31'd0, ovld(w)}, 32'd1);
        send(w, ADD, maxp, 16'd1, minn, 16'd0, 4'b0101, 1'b1);
        send(w, SUB, 16'd5, 16'd7, ones - 16'd1, 16'd0, 4'b0001, 1'b1);
        // Back-to-back carry chain: ADC must see the carry from the ADD just before it.
        send(w, ADD, ones, 16'd1, 16'd0, 16'd0, 4'b1010, 1'b1);
        send(w, ADC, 16'd0, 16'd0, 16'd1, 16'd0, 4'b0000, 1'b1);
        send(w, SBB, 16'd0, 16'd0, ones, 16'd0, 4'b0001, 1'b1);
        mul_lat(w, ones, ones, 16'd1, ones - 16'd1, 4'b1100);
        mul_lat(w, 16'd0, 16'h37, 16'd0, 16'd0, 4'b0010);
    endtask

    initial begin
        bit any_ov;
        drive(8, 1'b0, ADD, 16'd0, 16'd0);
        drive(16, 1'b0, ADD, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, if8.in_ready}, 32'd0);
        check("reset_outputs", {if8.out_valid, if8.result, if8.result_hi, if8.flag_c, if8.flag_v, if8.flag_z, if8.flag_n}, 32'd0);
        rst_n = 1'b1;
        #1 check("post_reset_in_ready", {31'd0, if8.in_ready}, 32'd1);

        arith_suite(8);
        // Logic ops clear C even right after a carry-producing ADD.
        send(8, ADD, 16'hFF, 16'h01, 16'h00, 16'd0, 4'b1010, 1'b1);
        send(8, AND_, 16'hF0, 16'h3C, 16'h30, 16'd0, 4'b0000, 1'b1);
        send(8, OR_,  16'h80, 16'h01, 16'h81, 16'd0, 4'b0001, 1'b1);
        send(8, XOR_, 16'hAA, 16'hAA, 16'h00, 16'd0, 4'b0010, 1'b1);
        mul_lat(8, 16'h0F, 16'h10, 16'hF0, 16'd0, 4'b0001);

        // Abort a MUL with a one-cycle reset during step 4.
        send(8, MUL, 16'h12, 16'h34, 16'd0, 16'd0, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready_in_reset", {31'd0, if8.in_ready}, 32'd0);
        check("abort_outputs_zero", {if8.out_valid, if8.result, if8.result_hi, if8.flag_c, if8.flag_v, if8.flag_z, if8.flag_n}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("abort_in_ready_after", {31'd0, if8.in_ready}, 32'd1);
        any_ov = 1'b0;
        repeat (15) begin
            @(negedge clk);
            any_ov |= if8.out_valid;
        end
        check("abort_no_out_valid", {31'd0, any_ov}, 32'd0);

        arith_suite(16);

        repeat (5) @(negedge clk);
        check("w8_queue_drained", q8.size(), 32'd0);
        check("w16_queue_drained", q16.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err + 1);
        $fatal(1, "watchdog");
    end
endmodule
